mips_multicycle_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS core: decodes the 6-bit opcode over several cycles and sequences the datapath through fetch, decode, execute, memory and write-back. It sits directly upstream of the ALU decoder and drives its 2-bit ALUOp. It also generates all datapath enables and mux selects, and waits on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 34 +++
 rtl/mips_ctrl_out_decode.sv | 76 +++++++
 rtl/mips_multicycle_ctrl.sv | 100 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle main control FSM and ALU decoder.
// Optional feature macro: MIPS_CTRL_ADDI_EN (adds the ADDIEXEC/ADDIWB states).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWR    = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
`ifdef MIPS_CTRL_ADDI_EN
        ,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath control word produced from the current state.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Bus between the main control FSM (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  op, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemRead, MemWrite,
               IRWrite, PCWrite, Branch, RegWrite, RegDst, MemtoReg,
               instr_done, illegal_op
    );

    modport slave (
        output op, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemRead, MemWrite,
               IRWrite, PCWrite, Branch, RegWrite, RegDst, MemtoReg,
               instr_done, illegal_op
    );
endinterface

// File: rtl/mips_ctrl_out_decode.sv
// Moore map from FSM state to the raw control word (before run/mem_ready gating).
// Optional feature macro: MIPS_CTRL_ADDI_EN.
module mips_ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    // Per-state control word; anything not set stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_MEMADR, S_ADDIEXEC: begin
`else
            S_MEMADR: begin
`endif
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
`endif
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// MIPS multi-cycle main control FSM: state register, next-state logic, run flop
// and mem_ready qualification of the fetch-stage write enables.
// Optional feature macro: MIPS_CTRL_ADDI_EN (ADDI support; otherwise ADDI is illegal).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input logic                     clk,
    input logic                     rst_n,
    mips_multicycle_ctrl_if.master  io_bus
);

    state_t r_state;
    state_t w_next;
    logic   r_run;
    logic   r_is_sw;
    logic   w_illegal;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;

    // State register; run holds the FSM idle (and outputs low) for one cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (r_run && r_state == S_DECODE)
                r_is_sw <= (io_bus.op == OP_SW);
        end
    end

    // Next-state decode; op is only looked at in DECODE (MEMADR uses the latched SW flag).
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH:  if (io_bus.mem_ready) w_next = S_DECODE;
                S_DECODE: begin
                    case (io_bus.op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_EXECUTE;
                        OP_BEQ:       w_next = S_BRANCH;
`ifdef MIPS_CTRL_ADDI_EN
                        OP_ADDI:      w_next = S_ADDIEXEC;
`endif
                        OP_J:         w_next = S_JUMP;
                        default: begin
                            w_next    = S_FETCH;
                            w_illegal = 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   w_next = r_is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:    if (io_bus.mem_ready) w_next = S_MEMWB;
                S_MEMWR:    if (io_bus.mem_ready) w_next = S_FETCH;
                S_EXECUTE:  w_next = S_ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
                S_ADDIEXEC: w_next = S_ADDIWB;
`endif
                default:    w_next = S_FETCH;
            endcase
        end
    end

    mips_ctrl_out_decode u_out_decode (
        .i_state (r_state),
        .o_ctrl  (w_dec)
    );

    // Output qualification: fetch writes wait for memory, everything is silent until run.
    always_comb begin
        w_ctrl = w_dec;
        if (r_state == S_FETCH) begin
            w_ctrl.ir_write = w_dec.ir_write & io_bus.mem_ready;
            w_ctrl.pc_write = w_dec.pc_write & io_bus.mem_ready;
        end
        if (!r_run)
            w_ctrl = '0;
    end

    assign io_bus.ALUOp      = w_ctrl.alu_op;
    assign io_bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign io_bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign io_bus.PCSrc      = w_ctrl.pc_src;
    assign io_bus.IorD       = w_ctrl.iord;
    assign io_bus.MemRead    = w_ctrl.mem_read;
    assign io_bus.MemWrite   = w_ctrl.mem_write;
    assign io_bus.IRWrite    = w_ctrl.ir_write;
    assign io_bus.PCWrite    = w_ctrl.pc_write;
    assign io_bus.Branch     = w_ctrl.branch;
    assign io_bus.RegWrite   = w_ctrl.reg_write;
    assign io_bus.RegDst     = w_ctrl.reg_dst;
    assign io_bus.MemtoReg   = w_ctrl.mem_to_reg;
    assign io_bus.instr_done = r_run & (w_next == S_FETCH) & (r_state != S_FETCH);
    assign io_bus.illegal_op = r_run & w_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes the hand-written
// expected output vector of each cycle, a monitor pops and compares at negedge.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.master)
    );

    // Output vector: {ALUOp,ALUSrcA,ALUSrcB,PCSrc,IorD,en[7:0],instr_done,illegal_op}
    // en = {MemRead,MemWrite,IRWrite,PCWrite,Branch,RegWrite,RegDst,MemtoReg}
    function automatic logic [17:0] mk(input logic [1:0] aop, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] pcs,
                                       input logic iord, input logic [7:0] en,
                                       input logic done, input logic ill);
        return {aop, sa, sb, pcs, iord, en, done, ill};
    endfunction

    localparam logic [17:0] E_ZERO     = 18'd0;
    localparam logic [17:0] E_FETCH    = mk(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 8'b1011_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_FWAIT    = mk(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 8'b1000_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_DECODE   = mk(2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 8'b0000_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_DEC_ILL  = mk(2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 8'b0000_0000, 1'b1, 1'b1);
    localparam logic [17:0] E_MEMADR   = mk(2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 8'b0000_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_MEMRD    = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 8'b1000_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_MEMWR_W  = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 8'b0100_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_MEMWR_D  = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 8'b0100_0000, 1'b1, 1'b0);
    localparam logic [17:0] E_MEMWB    = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_0101, 1'b1, 1'b0);
    localparam logic [17:0] E_EXEC     = mk(2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 8'b0000_0000, 1'b0, 1'b0);
    localparam logic [17:0] E_ALUWB    = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_0110, 1'b1, 1'b0);
    localparam logic [17:0] E_ADDIWB   = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_0100, 1'b1, 1'b0);
    localparam logic [17:0] E_BRANCH   = mk(2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 8'b0000_1000, 1'b1, 1'b0);
    localparam logic [17:0] E_JUMP     = mk(2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 8'b0001_0000, 1'b1, 1'b0);

    localparam logic [5:0] OP_BAD = 6'b111111;

    logic [17:0] exp_q[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_pushed = 0;

    wire [17:0] act = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.IorD,
                       bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                       bus.Branch, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                       bus.instr_done, bus.illegal_op};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One stimulus cycle: drive just after posedge, queue what must appear this cycle.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic rn,
                       input logic [17:0] e);
        @(posedge clk);
        #1;
        bus.op        = op;
        bus.mem_ready = rdy;
        rst_n         = rn;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL step%0d: outputs got %b required %b", n_tests, act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.op        = 6'd0;
        bus.mem_ready = 1'b1;

        // reset held 3 cycles, release cycle still silent
        repeat (3) cyc(OP_RTYPE, 1'b1, 1'b0, E_ZERO);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_ZERO);

        // LW, mem_ready ignored in DECODE/MEMADR, op ignored after DECODE
        cyc(OP_LW,    1'b1, 1'b1, E_FETCH);
        cyc(OP_LW,    1'b0, 1'b1, E_DECODE);
        cyc(OP_RTYPE, 1'b0, 1'b1, E_MEMADR);
        cyc(OP_LW,    1'b1, 1'b1, E_MEMRD);
        cyc(OP_LW,    1'b1, 1'b1, E_MEMWB);

        // R-type
        cyc(OP_RTYPE, 1'b1, 1'b1, E_FETCH);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_DECODE);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_EXEC);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_ALUWB);

        // BEQ
        cyc(OP_BEQ, 1'b1, 1'b1, E_FETCH);
        cyc(OP_BEQ, 1'b1, 1'b1, E_DECODE);
        cyc(OP_BEQ, 1'b1, 1'b1, E_BRANCH);

        // J
        cyc(OP_J, 1'b1, 1'b1, E_FETCH);
        cyc(OP_J, 1'b1, 1'b1, E_DECODE);
        cyc(OP_J, 1'b1, 1'b1, E_JUMP);

        // SW with two wait cycles in MEMWR
        cyc(OP_SW, 1'b1, 1'b1, E_FETCH);
        cyc(OP_SW, 1'b1, 1'b1, E_DECODE);
        cyc(OP_SW, 1'b1, 1'b1, E_MEMADR);
        cyc(OP_SW, 1'b0, 1'b1, E_MEMWR_W);
        cyc(OP_SW, 1'b0, 1'b1, E_MEMWR_W);
        cyc(OP_SW, 1'b1, 1'b1, E_MEMWR_D);

        // LW with a wait in FETCH and in MEMRD
        cyc(OP_LW, 1'b0, 1'b1, E_FWAIT);
        cyc(OP_LW, 1'b1, 1'b1, E_FETCH);
        cyc(OP_LW, 1'b1, 1'b1, E_DECODE);
        cyc(OP_LW, 1'b1, 1'b1, E_MEMADR);
        cyc(OP_LW, 1'b0, 1'b1, E_MEMRD);
        cyc(OP_LW, 1'b1, 1'b1, E_MEMRD);
        cyc(OP_LW, 1'b1, 1'b1, E_MEMWB);

        // illegal opcode
        cyc(OP_BAD, 1'b1, 1'b1, E_FETCH);
        cyc(OP_BAD, 1'b1, 1'b1, E_DEC_ILL);

        // ADDI
        cyc(OP_ADDI, 1'b1, 1'b1, E_FETCH);
`ifdef MIPS_CTRL_ADDI_EN
        cyc(OP_ADDI, 1'b1, 1'b1, E_DECODE);
        cyc(OP_ADDI, 1'b1, 1'b1, E_MEMADR);
        cyc(OP_ADDI, 1'b1, 1'b1, E_ADDIWB);
`else
        cyc(OP_ADDI, 1'b1, 1'b1, E_DEC_ILL);
`endif

        // reset asserted in MEMRD aborts at once, then a clean restart
        cyc(OP_LW, 1'b1, 1'b1, E_FETCH);
        cyc(OP_LW, 1'b1, 1'b1, E_DECODE);
        cyc(OP_LW, 1'b1, 1'b1, E_MEMADR);
        cyc(OP_LW, 1'b0, 1'b1, E_MEMRD);
        cyc(OP_LW, 1'b1, 1'b0, E_ZERO);
        cyc(OP_LW, 1'b1, 1'b0, E_ZERO);
        cyc(OP_LW, 1'b1, 1'b1, E_ZERO);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_FETCH);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_DECODE);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_EXEC);
        cyc(OP_RTYPE, 1'b1, 1'b1, E_ALUWB);

        repeat (3) @(posedge clk);
        if (n_tests != n_pushed) begin
            n_fail++;
            $display("FAIL drain: checked %0d required %0d", n_tests, n_pushed);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
